host_rdback: RTL and testbench
==============================

// Module: host_rdback
// PURPOSE
//  Host-side readback engine; counterpart of the host write-loader.
//  - Takes a one-byte address from the host byte link and issues one single-word Wishbone classic read.
//  - Returns the 32-bit read data to the host byte transmitter, 4 bytes, LSB first.
//  - Used to verify memory contents after program load, while the CPU is held in reset.
// PARAMETERS
//  ADDR_BASE   32'h0000_0000  base added to the shifted address byte
//  ADDR_SHIFT  0              left shift of the address byte (0 = byte index, 2 = word index)
//  TIMEOUT     255            max cycles to wait for ack_i/err_i (1..65535)
//  ERR_WORD    32'hDEAD_BEEF  word returned on timeout or bus error
// PORTS
//  clk_i        in   1   clock; all logic on rising edge
//  rst_i        in   1   synchronous active-high reset
//  en_i         in   1   readback mode enable; rx bytes ignored while low
//  rx_data_i    in   8   address byte from host receiver
//  rx_valid_i   in   1   1-cycle strobe, rx_data_i valid
//  tx_data_o    out  8   byte to host transmitter
//  tx_valid_o   out  1   tx_data_o valid; held until accepted
//  tx_ready_i   in   1   transmitter accepts byte when tx_valid_o&tx_ready_i
//  wb_adr_o     out  32  ADDR_BASE + (addr_byte << ADDR_SHIFT)
//  wb_dat_i     in   32  read data
//  wb_ack_i     in   1   slave acknowledge
//  wb_err_i     in   1   slave error
//  wb_cyc_o     out  1   bus cycle
//  wb_stb_o     out  1   strobe (equals wb_cyc_o)
//  wb_we_o      out  1   constant 0
//  wb_sel_o     out  4   constant 4'hF
//  wb_cti_o     out  3   constant 3'b000
//  wb_bte_o     out  2   constant 2'b00
//  busy_o       out  1   high in any state except IDLE
//  done_o       out  1   1-cycle pulse after 4th byte accepted
//  err_o        out  1   1-cycle pulse on timeout or wb_err_i
//  overrun_o    out  1   1-cycle pulse when rx_valid_i arrives while busy
// BEHAVIOUR
//  - Reset: state IDLE; wb_cyc_o, wb_stb_o, tx_valid_o, done_o, err_o, overrun_o, busy_o = 0; wb_adr_o, tx_data_o = 0; byte counter 0.
//  - Reset mid-operation aborts immediately; cyc/stb drop on the next edge; no done_o.
//  - States: IDLE -> WB_RD -> TX -> IDLE.
//  - IDLE: rx_valid_i&en_i at edge N latches the address; wb_adr_o valid and cyc/stb=1 from N+1.
//  - WB_RD: cyc/stb held, timeout counter increments each cycle.
//    - ack_i: capture wb_dat_i.
//    - err_i (ack wins if both set) or counter reaching TIMEOUT: capture ERR_WORD, pulse err_o.
//    - Any of these deasserts cyc/stb on the same edge and enters TX.
//    - Timeout counter is sized $clog2(TIMEOUT+1) and cleared on entry to WB_RD.
//  - TX: tx_valid_o=1 with byte k (k=0..3, data[8k+7:8k]); tx_data_o stable while valid&!ready.
//    - On valid&ready, k increments and the next byte is presented the following cycle. Min 1 cycle per byte.
//    - After byte 3 is accepted: tx_valid_o=0, done_o=1 for one cycle, return to IDLE.
//  - Read latency: rx strobe to tx_valid_o >= 2 cycles (ack in the 1st cycle of cyc gives exactly 2).
//  - rx_valid_i while busy_o: byte dropped, overrun_o pulses, operation continues unaffected.
//  - rx_valid_i with en_i=0 in IDLE: ignored, no pulse. Dropping en_i mid-operation does not abort.
//  - A new address is accepted in the same cycle IDLE is re-entered (back-to-back allowed the cycle after done_o).
// TESTING
//  - ADDR_SHIFT=0: rx 8'h10, slave acks after 3 cycles with 32'h1122_3344, tx_ready_i=1
//    -> wb_adr_o=32'h10, we=0, sel=F; tx bytes 44,33,22,11; done_o one pulse.
//  - tx_ready_i low 5 cycles on byte 1 -> tx_data_o holds 8'h33, no byte lost or duplicated.
//  - No ack, TIMEOUT=255 -> cyc drops after exactly 255 cycles; err_o pulse; bytes EF,BE,AD,DE.
//  - wb_err_i on cycle 2 -> err_o pulse, ERR_WORD returned; ack+err same cycle -> data from wb_dat_i.
//  - rx strobe during TX -> overrun_o pulse, current reply intact; rx with en_i=0 -> no bus cycle.
//  - rst_i asserted mid WB_RD and mid TX -> next cycle all outputs at reset values; new rx after reset works.

Source files
------------

// File: rtl/host_rdback.sv
// Host readback engine: one address byte in, one Wishbone classic read, four reply bytes out LSB first.
// Latency rx->tx_valid >= 2 cycles; reply bytes held until tx_ready_i, rx bytes arriving while busy are dropped.
module host_rdback #(
  parameter logic [31:0] ADDR_BASE  = 32'h0000_0000,
  parameter int          ADDR_SHIFT = 0,
  parameter int          TIMEOUT    = 255,
  parameter logic [31:0] ERR_WORD   = 32'hDEAD_BEEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic [31:0] wb_adr_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic [2:0]  wb_cti_o,
  output logic [1:0]  wb_bte_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic        overrun_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_WB_RD, S_TX} state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_adr;
  logic [31:0]   r_data;
  logic [1:0]    r_k;
  logic          r_done, r_err, r_ovr;
  logic          w_cyc, w_tx_vld, w_timeout, w_last_acc;
  logic [31:0]   w_adr_nxt;

  // Counter starts at 0 on the first bus cycle, so TIMEOUT-1 marks the last allowed cycle.
  assign w_timeout  = (r_cnt == CW'(TIMEOUT - 1));
  assign w_last_acc = (r_state == S_TX) && tx_ready_i && (r_k == 2'd3);
  assign w_adr_nxt  = ADDR_BASE + ({24'h0, rx_data_i} << ADDR_SHIFT);

  always_comb begin
    w_state_nxt = r_state;
    w_cyc       = 1'b0;
    w_tx_vld    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (rx_valid_i && en_i) w_state_nxt = S_WB_RD;
      end
      S_WB_RD: begin
        w_cyc = 1'b1;
        if (wb_ack_i || wb_err_i || w_timeout) w_state_nxt = S_TX;
      end
      S_TX: begin
        w_tx_vld = 1'b1;
        if (w_last_acc) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_adr   <= '0;
      r_data  <= '0;
      r_k     <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_last_acc;
      r_err   <= (r_state == S_WB_RD) && !wb_ack_i && (wb_err_i || w_timeout);
      r_ovr   <= rx_valid_i && (r_state != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (rx_valid_i && en_i) begin
            r_adr <= w_adr_nxt;
            r_cnt <= '0;
            r_k   <= '0;
          end
        end
        S_WB_RD: begin
          r_cnt <= r_cnt + 1'b1;
          // Ack takes priority over a simultaneous error.
          if (wb_ack_i)                   r_data <= wb_dat_i;
          else if (wb_err_i || w_timeout) r_data <= ERR_WORD;
        end
        S_TX: begin
          if (tx_ready_i) r_k <= r_k + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign tx_valid_o = w_tx_vld;
  assign tx_data_o  = w_tx_vld ? r_data[{r_k, 3'b000} +: 8] : 8'h00;
  assign wb_adr_o   = r_adr;
  assign wb_cyc_o   = w_cyc;
  assign wb_stb_o   = w_cyc;
  assign wb_we_o    = 1'b0;
  assign wb_sel_o   = 4'hF;
  assign wb_cti_o   = 3'b000;
  assign wb_bte_o   = 2'b00;
  assign busy_o     = (r_state != S_IDLE);
  assign done_o     = r_done;
  assign err_o      = r_err;
  assign overrun_o  = r_ovr;

endmodule

// File: tb/tb_host_rdback.sv
// Scoreboard bench for host_rdback: expected reply bytes queued at stimulus, checked as the DUT sends them.
module tb_host_rdback;

  logic        clk = 1'b0;
  logic        rst_i, en_i, rx_valid_i, tx_ready_i;
  logic [7:0]  rx_data_i, tx_data_o;
  logic        tx_valid_o;
  logic [31:0] wb_adr_o, wb_dat_i;
  logic        wb_ack_i, wb_err_i, wb_cyc_o, wb_stb_o, wb_we_o;
  logic [3:0]  wb_sel_o;
  logic [2:0]  wb_cti_o;
  logic [1:0]  wb_bte_o;
  logic        busy_o, done_o, err_o, overrun_o;

  host_rdback dut (
    .clk_i(clk), .rst_i(rst_i), .en_i(en_i),
    .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i),
    .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
    .wb_adr_o(wb_adr_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o),
    .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .overrun_o(overrun_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Slave model configuration: mode 0=ack, 1=err, 2=silent, 3=ack+err together
  int          sl_mode  = 0;
  int          sl_delay = 1;
  logic [31:0] sl_data  = '0;

  int          cyc_cnt = 0, last_len = 0, n_starts = 0, cyc_no = 0;
  logic [31:0] cap_adr = '0;
  int          n_done = 0, n_err = 0, n_ovr = 0;
  int          t_rx = 0, t_tx = 0;
  logic        prev_vld = 1'b0;
  logic [7:0]  exp_q[$];
  logic [7:0]  popped;

  always @(posedge clk) cyc_no++;

  always @(posedge clk) begin
    #1;
    if (wb_cyc_o) begin
      cyc_cnt++;
      if (cyc_cnt == 1) begin
        n_starts++;
        cap_adr = wb_adr_o;
        check("wb_we", {31'h0, wb_we_o}, 32'h0);
        check("wb_sel", {28'h0, wb_sel_o}, 32'hF);
        check("wb_stb", {31'h0, wb_stb_o}, 32'h1);
        check("wb_cti_bte", {27'h0, wb_cti_o, wb_bte_o}, 32'h0);
      end
    end else begin
      if (cyc_cnt != 0) last_len = cyc_cnt;
      cyc_cnt = 0;
    end
    wb_ack_i = wb_cyc_o && (sl_mode == 0 || sl_mode == 3) && (cyc_cnt == sl_delay);
    wb_err_i = wb_cyc_o && (sl_mode == 1 || sl_mode == 3) && (cyc_cnt == sl_delay);
    wb_dat_i = wb_ack_i ? sl_data : 32'h0BAD_F00D;
  end

  always @(negedge clk) begin
    if (tx_valid_o && !prev_vld) t_tx = cyc_no;
    prev_vld = tx_valid_o;
    if (done_o)    n_done++;
    if (err_o)     n_err++;
    if (overrun_o) n_ovr++;
    if (tx_valid_o) begin
      if (exp_q.size() == 0) check("tx_extra", 32'h1, 32'h0);
      else begin
        check("tx_byte", {24'h0, tx_data_o}, {24'h0, exp_q[0]});
        if (tx_ready_i) popped = exp_q.pop_front();
      end
    end
  end

  task automatic push_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) exp_q.push_back(w[8*k +: 8]);
  endtask

  task automatic send(input logic [7:0] a);
    @(posedge clk); #1;
    rx_data_i = a; rx_valid_i = 1'b1; t_rx = cyc_no;
    @(posedge clk); #1;
    rx_valid_i = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int i;
    for (i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!busy_o && exp_q.size() == 0) break;
    end
    check(tag, {31'h0, i < 3000}, 32'h1);
    @(posedge clk); #1;
  endtask

  task automatic wait_vld(input string tag);
    int i;
    for (i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx_valid_o) break;
    end
    check(tag, {31'h0, i < 100}, 32'h1);
  endtask

  task automatic cfg(input int mode, input int dly, input logic [31:0] d);
    sl_mode = mode; sl_delay = dly; sl_data = d;
    push_word((mode == 0 || mode == 3) ? d : 32'hDEAD_BEEF);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_ctl"}, {25'h0, wb_cyc_o, wb_stb_o, tx_valid_o, done_o, err_o, overrun_o, busy_o}, 32'h0);
    check({tag, "_adr"}, wb_adr_o, 32'h0);
    check({tag, "_txd"}, {24'h0, tx_data_o}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int d_done, d_err, d_ovr, d_st;

  initial begin
    rst_i = 1'b1; en_i = 1'b1; rx_valid_i = 1'b0; rx_data_i = '0; tx_ready_i = 1'b1;
    wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_dat_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_quiet("reset");
    @(posedge clk); #1 rst_i = 1'b0;

    // basic read, ack on 3rd bus cycle
    d_done = n_done; d_err = n_err;
    cfg(0, 3, 32'h1122_3344);
    send(8'h10);
    wait_idle("t1_idle");
    check("t1_adr", cap_adr, 32'h10);
    check("t1_len", last_len, 3);
    check("t1_done", n_done - d_done, 1);
    check("t1_err", n_err - d_err, 0);

    // byte 1 stalled for several cycles
    cfg(0, 1, 32'h1122_3344);
    tx_ready_i = 1'b0;
    send(8'h20);
    wait_vld("t2_vld");
    @(posedge clk); #1 tx_ready_i = 1'b1;
    @(posedge clk); #1 tx_ready_i = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("t2_hold", {24'h0, tx_data_o}, 32'h33);
    @(posedge clk); #1 tx_ready_i = 1'b1;
    wait_idle("t2_idle");

    // silent slave: timeout after exactly TIMEOUT cycles
    d_done = n_done; d_err = n_err;
    cfg(2, 1, 32'h0);
    send(8'h21);
    wait_idle("t3_idle");
    check("t3_len", last_len, 255);
    check("t3_err", n_err - d_err, 1);
    check("t3_done", n_done - d_done, 1);

    // bus error on 2nd cycle
    d_err = n_err;
    cfg(1, 2, 32'h0);
    send(8'h22);
    wait_idle("t4_idle");
    check("t4_len", last_len, 2);
    check("t4_err", n_err - d_err, 1);

    // ack and err together: data wins, minimum latency
    d_err = n_err;
    cfg(3, 1, 32'hA5A5_5A5A);
    send(8'h23);
    wait_idle("t5_idle");
    check("t5_err", n_err - d_err, 0);
    check("t5_lat", t_tx - t_rx, 2);

    // rx during TX: overrun pulse, reply intact
    d_ovr = n_ovr; d_st = n_starts;
    cfg(0, 2, 32'h5566_7788);
    tx_ready_i = 1'b0;
    send(8'h30);
    wait_vld("t6_vld");
    send(8'h31);
    @(posedge clk); #1 tx_ready_i = 1'b1;
    wait_idle("t6_idle");
    check("t6_ovr", n_ovr - d_ovr, 1);
    check("t6_starts", n_starts - d_st, 1);
    check("t6_adr", cap_adr, 32'h30);

    // disabled: no bus cycle, no pulse
    d_ovr = n_ovr; d_st = n_starts;
    en_i = 1'b0;
    send(8'h40);
    repeat (5) @(posedge clk);
    #1;
    check("t7_starts", n_starts - d_st, 0);
    check("t7_busy", {31'h0, busy_o}, 32'h0);
    check("t7_ovr", n_ovr - d_ovr, 0);
    en_i = 1'b1;

    // reset in WB_RD
    d_done = n_done; d_err = n_err;
    sl_mode = 2;
    send(8'h50);
    repeat (10) @(posedge clk);
    #1 rst_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_quiet("rst_rd");
    @(posedge clk); #1 rst_i = 1'b0;
    check("rst_rd_pulses", (n_done - d_done) + (n_err - d_err), 0);

    // reset in TX
    d_done = n_done;
    cfg(0, 1, 32'h99AA_BBCC);
    tx_ready_i = 1'b0;
    send(8'h60);
    wait_vld("rst_tx_vld");
    @(posedge clk); #1 rst_i = 1'b1;
    @(posedge clk); #1 exp_q.delete();
    @(negedge clk);
    check_quiet("rst_tx");
    @(posedge clk); #1 rst_i = 1'b0; tx_ready_i = 1'b1;
    check("rst_tx_done", n_done - d_done, 0);

    // read after reset
    cfg(0, 4, 32'hCAFE_F00D);
    send(8'hFF);
    wait_idle("t8_idle");
    check("t8_adr", cap_adr, 32'hFF);

    // back-to-back: next rx lands in the done cycle
    d_done = n_done; d_ovr = n_ovr; d_st = n_starts;
    cfg(0, 1, 32'h0403_0201);
    send(8'h70);
    begin
      int i;
      for (i = 0; i < 100; i++) begin
        @(negedge clk);
        if (tx_valid_o && tx_data_o == 8'h04) break;
      end
      check("t9_last", {31'h0, i < 100}, 32'h1);
    end
    push_word(32'h0403_0201);
    send(8'h71);
    wait_idle("t9_idle");
    check("t9_starts", n_starts - d_st, 2);
    check("t9_done", n_done - d_done, 2);
    check("t9_ovr", n_ovr - d_ovr, 0);
    check("t9_adr", cap_adr, 32'h71);

    check("q_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
